// File: rtl/rand_op_unit.sv
// CHIP-8 CXNN execution unit: VX = random byte & NN.
// Random bytes are prefetched into a small FIFO so every accepted CXNN has one ready.
module rand_op_unit #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rnd_byte,
    input  logic                         op_valid,
    input  logic [15:0]                  op,
    output logic                         op_ready,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [3:0]                   wr_idx,
    output logic [7:0]                   wr_data,
    output logic                         err_opcode,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          accept;
    logic          is_cxnn;
    logic          pop;
    logic          push;
    logic [7:0]    head;

    assign wr_valid = (state == WRITE);
    assign op_ready = (!wr_valid || wr_ready) && (level != '0);
    assign accept   = op_valid && op_ready;
    assign is_cxnn  = (op[15:12] == 4'hC);
    assign pop      = accept && is_cxnn;
    // A full FIFO still takes a new byte when the head leaves in the same cycle.
    assign push     = (level != LW'(DEPTH)) || pop;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rnd_byte;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_idx     <= '0;
            wr_data    <= '0;
            err_opcode <= 1'b0;
        end else begin
            err_opcode <= accept && !is_cxnn;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= WRITE;
                        wr_idx  <= op[11:8];
                        wr_data <= head & op[7:0];
                    end
                end
                WRITE: begin
                    // A retiring write may be replaced in the same cycle for full throughput.
                    if (pop) begin
                        wr_idx  <= op[11:8];
                        wr_data <= head & op[7:0];
                    end else if (wr_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rand_op_unit.md
RAND_OP_UNIT -- requirements
Module: rand_op_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning random-byte prefetch buffer depth; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low; rst=0 resets all state immediately.
REQ-004 SHALL have port rnd_byte, input, 8, random byte from the generator, which produces a new value every clk.
REQ-005 SHALL have port op_valid, input, 1, instruction word offered.
REQ-006 SHALL have port op, input, 16, CHIP-8 instruction word; CXNN is op[15:12]=4'hC, X=op[11:8], NN=op[7:0].
REQ-007 SHALL have port op_ready, output, 1, instruction accepted this cycle when op_valid=1.
REQ-008 SHALL have port wr_valid, output, 1, register write pending.
REQ-009 SHALL have port wr_ready, input, 1, register file takes the write this cycle.
REQ-010 SHALL have port wr_idx, output, 4, destination register VX.
REQ-011 SHALL have port wr_data, output, 8, value to write.
REQ-012 SHALL have port err_opcode, output, 1, one-cycle pulse: accepted word was not CXNN.
REQ-013 SHALL have port level, output, clog2(DEPTH+1), number of buffered random bytes.

Function
REQ-014 SHALL keep a DEPTH-entry FIFO of random bytes; push rnd_byte on a cycle when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
REQ-015 SHALL pop bytes in push order; level SHALL equal pushes minus pops and never exceed DEPTH or underflow.
REQ-016 SHALL drive op_ready = (wr_valid=0 or wr_ready=1) and level>0; op_ready SHALL NOT depend combinationally on op_valid or op.
REQ-017 SHALL treat an accept as op_valid=1 and op_ready=1 on a rising clk edge.
REQ-018 On accept of CXNN, SHALL pop the FIFO head H and, next cycle, drive wr_valid=1, wr_idx=X, wr_data=H & NN; latency is exactly 1 cycle.
REQ-019 On accept of a non-CXNN word, SHALL NOT pop the FIFO and SHALL NOT assert wr_valid; SHALL assert err_opcode for exactly the next cycle.
REQ-020 While wr_valid=1 and wr_ready=0, SHALL hold wr_idx and wr_data stable and accept no op.
REQ-021 On wr_valid=1 and wr_ready=1 with no new accept, SHALL drop wr_valid to 0 next cycle.
REQ-022 On wr_valid=1 and wr_ready=1 with a same-cycle CXNN accept, SHALL present the new write next cycle with wr_valid remaining 1, giving back-to-back throughput of one write per cycle.
REQ-023 SHALL use a two-state output FSM: IDLE (wr_valid=0) and WRITE (wr_valid=1); transitions follow REQ-018, REQ-021 and REQ-022.
REQ-024 When NN=8'h00, SHALL still pop and write 8'h00.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH without loss or duplication of bytes.

Reset
REQ-026 While rst=0, SHALL force wr_valid=0, err_opcode=0, level=0, wr_idx=0, wr_data=0, op_ready=0 and FSM=IDLE, and SHALL discard FIFO contents.
REQ-027 Assertion of rst in WRITE SHALL abandon the pending write, with no wr_valid after release until a new accept.
REQ-028 On the first clk edge after rst returns to 1, SHALL begin filling the FIFO.

Verification
REQ-029 Reset release, rnd_byte=11,22,33,44,55 on successive edges, op_valid=0 -> level=1,2,3,4,4; FIFO holds 11,22,33,44.
REQ-030 From the REQ-029 state, accept op=C3F0, wr_ready=1 -> next cycle wr_valid=1, wr_idx=3, wr_data=10; then accept C70F -> wr_idx=7, wr_data=02, back-to-back.
REQ-031 With wr_valid=1 and wr_ready=0 for 3 cycles, op_valid=1 -> op_ready=0 throughout, wr_idx/wr_data unchanged, write retires on the first wr_ready=1 cycle.
REQ-032 Accept op=6123 -> err_opcode=1 for one cycle, wr_valid stays 0, no pop; level rises to 4 (or stays at 4 if already full).
REQ-033 op_valid=1 held from reset release -> op_ready=0 in the first cycle, 1 once level>=1; wr_data = first pushed byte & NN.
REQ-034 rst=0 driven mid-cycle while wr_valid=1 and level=3 -> wr_valid=0 and level=0 immediately without a clk edge; no write after release.
